// File: rtl/xbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : xbus_pkg                                                |
// | Description: Shared size codes, FSM state type and beat-count helper |
// |              for the X-port to 16-bit narrow-bus bridge.             |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package xbus_pkg;

  localparam logic [1:0] SIZ_BYTE  = 2'd0;
  localparam logic [1:0] SIZ_HALF  = 2'd1;
  localparam logic [1:0] SIZ_WORD  = 2'd2;
  localparam logic [1:0] SIZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Number of 16-bit beats needed to move one transfer of the given size.
  function automatic logic [2:0] beats_for_siz(input logic [1:0] siz);
    logic [2:0] n;
    case (siz)
      SIZ_BYTE, SIZ_HALF: n = 3'd1;
      SIZ_WORD:           n = 3'd2;
      default:            n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xbus_rd_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : xbus_rd_extend                                          |
// | Description: Selects the addressed part of the assembled read data   |
// |              and sign- or zero-extends it to 64 bits.                |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module xbus_rd_extend
  import xbus_pkg::*;
(
  input  logic [63:0] asm_i,
  input  logic [1:0]  siz_i,
  input  logic        lane_i,
  input  logic        signed_i,
  output logic [63:0] xdat_o
);

  logic [7:0] byte_sel;

  // Pick the byte lane for byte reads, then extend to the full X-port width.
  always_comb begin
    byte_sel = lane_i ? asm_i[15:8] : asm_i[7:0];
    case (siz_i)
      SIZ_BYTE: xdat_o = {{56{signed_i & byte_sel[7]}}, byte_sel};
      SIZ_HALF: xdat_o = {{48{signed_i & asm_i[15]}}, asm_i[15:0]};
      SIZ_WORD: xdat_o = {{32{signed_i & asm_i[31]}}, asm_i[31:0]};
      default:  xdat_o = asm_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/xbus_n16_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : xbus_n16_bridge                                         |
// | Description: X-port slave that sequences each 64-bit transaction     |
// |              into 1-4 halfword beats on an SRAM-style 16-bit bus     |
// |              with programmable wait states.                          |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module xbus_n16_bridge
  import xbus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int NADR_W      = 24
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [63:0]       xdat_i,
  input  logic [63:0]       xadr_i,
  input  logic              xwe_i,
  input  logic              xcyc_i,
  input  logic              xstb_i,
  input  logic [1:0]        xsiz_i,
  input  logic              xsigned_i,
  output logic              xack_o,
  output logic [63:0]       xdat_o,
  output logic [NADR_W-1:0] nadr_o,
  output logic [15:0]       ndat_o,
  input  logic [15:0]       ndat_i,
  output logic              ncs_o,
  output logic              nwe_o,
  output logic [1:0]        nbe_o
);

  localparam logic [3:0] c_wait_last = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [NADR_W-1:0]   adr_q, adr_d;
  logic [63:0]         dat_q, dat_d;
  logic                we_q, we_d;
  logic [1:0]          siz_q, siz_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0]          wait_q, wait_d;
  logic [63:0]         asm_q, asm_d;

  logic                xack_q, xack_d;
  logic [63:0]         xdat_q, xdat_d;
  logic [NADR_W-1:0]   nadr_q, nadr_d;
  logic [15:0]         ndat_q, ndat_d;
  logic                ncs_q, ncs_d;
  logic                nwe_q, nwe_d;
  logic [1:0]          nbe_q, nbe_d;

  logic [63:0]         asm_merge;
  logic [63:0]         ext_dat;
  logic [2:0]          beat_cnt;
  logic [1:0]          beat_last;
  logic [NADR_W-1:0]   align_mask;
  logic [NADR_W-1:0]   base_even;

  // Address bits above the narrow-bus width have no meaning here.
  logic unused_xadr_hi;
  assign unused_xadr_hi = ^xadr_i[63:NADR_W];

  assign beat_cnt  = beats_for_siz(siz_q);
  assign beat_last = 2'(beat_cnt - 3'd1);

  // Drop the halfword currently on the bus into its slot of the assembly register.
  always_comb begin
    asm_merge = asm_q;
    asm_merge[{beat_q, 4'b0000} +: 16] = ndat_i;
  end

  // The final beat's sample must be visible to the extender in the same cycle it is taken.
  xbus_rd_extend u_rd_extend (
    .asm_i    (asm_merge),
    .siz_i    (siz_q),
    .lane_i   (adr_q[0]),
    .signed_i (sgn_q),
    .xdat_o   (ext_dat)
  );

  // Next-state, counters, latches, and the next value of every registered output.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    siz_d      = siz_q;
    sgn_d      = sgn_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    asm_d      = asm_q;
    xack_d     = 1'b0;
    xdat_d     = 64'd0;
    align_mask = '1;
    base_even  = '0;

    case (state_q)
      IDLE: begin
        if (xcyc_i && xstb_i) begin
          state_d = BEAT;
          adr_d   = xadr_i[NADR_W-1:0];
          dat_d   = xdat_i;
          we_d    = xwe_i;
          siz_d   = xsiz_i;
          sgn_d   = xsigned_i;
          beat_d  = 2'd0;
          wait_d  = 4'd0;
          asm_d   = 64'd0;
        end
      end
      BEAT: begin
        if (!xcyc_i) begin
          // Master gave up the cycle: leave without acknowledging.
          state_d = IDLE;
          beat_d  = 2'd0;
          wait_d  = 4'd0;
        end else if (wait_q == c_wait_last) begin
          if (!we_q) begin
            asm_d = asm_merge;
          end
          wait_d = 4'd0;
          if (beat_q == beat_last) begin
            state_d = ACK;
            beat_d  = 2'd0;
            xack_d  = 1'b1;
            xdat_d  = we_q ? 64'd0 : ext_dat;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Even-aligned base of the transfer; byte accesses keep their lane via nbe.
    case (siz_d)
      SIZ_BYTE, SIZ_HALF: align_mask = {{(NADR_W-1){1'b1}}, 1'b0};
      SIZ_WORD:           align_mask = {{(NADR_W-2){1'b1}}, 2'b00};
      default:            align_mask = {{(NADR_W-3){1'b1}}, 3'b000};
    endcase
    base_even = adr_d & align_mask;

    ncs_d  = (state_d == BEAT);
    nwe_d  = ncs_d & we_d;
    nadr_d = ncs_d ? (base_even + {{(NADR_W-3){1'b0}}, beat_d, 1'b0}) : '0;
    if (!ncs_d) begin
      nbe_d = 2'b00;
    end else if (siz_d == SIZ_BYTE) begin
      nbe_d = adr_d[0] ? 2'b10 : 2'b01;
    end else begin
      nbe_d = 2'b11;
    end
    if (!nwe_d) begin
      ndat_d = 16'd0;
    end else if (siz_d == SIZ_BYTE) begin
      ndat_d = {dat_d[7:0], dat_d[7:0]};
    end else begin
      ndat_d = dat_d[{beat_d, 4'b0000} +: 16];
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= 64'd0;
      we_q    <= 1'b0;
      siz_q   <= 2'd0;
      sgn_q   <= 1'b0;
      beat_q  <= 2'd0;
      wait_q  <= 4'd0;
      asm_q   <= 64'd0;
      xack_q  <= 1'b0;
      xdat_q  <= 64'd0;
      nadr_q  <= '0;
      ndat_q  <= 16'd0;
      ncs_q   <= 1'b0;
      nwe_q   <= 1'b0;
      nbe_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      siz_q   <= siz_d;
      sgn_q   <= sgn_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      asm_q   <= asm_d;
      xack_q  <= xack_d;
      xdat_q  <= xdat_d;
      nadr_q  <= nadr_d;
      ndat_q  <= ndat_d;
      ncs_q   <= ncs_d;
      nwe_q   <= nwe_d;
      nbe_q   <= nbe_d;
    end
  end

  assign xack_o = xack_q;
  assign xdat_o = xdat_q;
  assign nadr_o = nadr_q;
  assign ndat_o = ndat_q;
  assign ncs_o  = ncs_q;
  assign nwe_o  = nwe_q;
  assign nbe_o  = nbe_q;

endmodule
`default_nettype wire
